// File: rtl/vwb_pkg.sv
// Shared types and constants for the vector writeback collector.
// SAT_POS/SAT_NEG are the saturation limits at the default element width.
package vwb_pkg;

    localparam int DEF_LANES = 16;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREG  = 8;

    localparam logic [DEF_WIDTH-1:0] SAT_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } vwb_state_t;

endpackage

// File: rtl/vwb_collect_if.sv
// Bundle between the adder/sequencer side (master) and the collector (slave).
// Carries the command, element stream, register-file write port and status.
interface vwb_collect_if
    import vwb_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
);
    logic                     cmd_start;
    logic [$clog2(NREG)-1:0]  cmd_vreg;
    logic                     abort;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ov;
    logic                     in_sign;
    logic                     in_ready;
    logic                     rf_we;
    logic [$clog2(NREG)-1:0]  rf_vreg;
    logic [$clog2(LANES)-1:0] rf_elem;
    logic [WIDTH-1:0]         rf_wdata;
    logic                     V;
    logic                     busy;
    logic                     done;

    modport master (
        output cmd_start, cmd_vreg, abort, in_valid, in_data, in_ov, in_sign,
        input  in_ready, rf_we, rf_vreg, rf_elem, rf_wdata, V, busy, done
    );

    modport slave (
        input  cmd_start, cmd_vreg, abort, in_valid, in_data, in_ov, in_sign,
        output in_ready, rf_we, rf_vreg, rf_elem, rf_wdata, V, busy, done
    );
endinterface

// File: rtl/vwb_buf.sv
// LANES x WIDTH element buffer: one write port, asynchronous read port.
// No reset; contents are only meaningful after a full vector is collected.
module vwb_buf #(
    parameter int LANES = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(LANES)-1:0] widx,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(LANES)-1:0] ridx,
    output logic [WIDTH-1:0]         rdata
);
    localparam int EW = $clog2(LANES);

    logic [WIDTH-1:0] r_mem [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (we && (widx == EW'(gi))) begin
                    r_mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_mem[ridx];

endmodule

// File: rtl/vwb_collect.sv
// Vector writeback collector: buffers one vector from the serial adder, then
// commits it to the register file one element per cycle. Option: VWB_SAT_EN.
module vwb_collect
    import vwb_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
) (
    input  logic         Clk,
    input  logic         Rst_n,
    vwb_collect_if.slave bus
);
    localparam int EW = $clog2(LANES);
    localparam int VW = $clog2(NREG);
    localparam logic [EW-1:0] LAST = EW'(LANES - 1);

    vwb_state_t       r_state;
    logic [EW-1:0]    r_cnt;
    logic [EW-1:0]    r_wcnt;
    logic [VW-1:0]    r_vreg;
    logic             r_v;
    logic             r_ready;
    logic             r_we;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic [WIDTH-1:0] w_store;
    logic [WIDTH-1:0] w_rdata;

    // An element arriving together with abort is dropped, never stored.
    assign w_accept = (r_state == COLLECT) && bus.in_valid && !bus.abort;

`ifdef VWB_SAT_EN
    localparam logic [WIDTH-1:0] L_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_store = !bus.in_ov ? bus.in_data : (bus.in_sign ? L_SAT_NEG : L_SAT_POS);
`else
    logic w_unused_sign;
    assign w_unused_sign = bus.in_sign;
    assign w_store       = bus.in_data;
`endif

    vwb_buf #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_buf (
        .clk   (Clk),
        .we    (w_accept),
        .widx  (r_cnt),
        .wdata (w_store),
        .ridx  (r_wcnt),
        .rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_vreg  <= '0;
            r_v     <= 1'b0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        r_state <= COLLECT;
                        r_vreg  <= bus.cmd_vreg;
                        r_cnt   <= '0;
                        r_v     <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_v     <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (bus.in_valid) begin
                        r_v <= r_v | bus.in_ov;
                        if (r_cnt == LAST) begin
                            r_state <= WRITE;
                            r_cnt   <= '0;
                            r_wcnt  <= '0;
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (r_wcnt == LAST) begin
                        r_state <= DONE;
                        r_wcnt  <= '0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.rf_we    = r_we;
    assign bus.rf_vreg  = r_vreg;
    assign bus.rf_elem  = r_wcnt;
    assign bus.rf_wdata = r_we ? w_rdata : '0;
    assign bus.V        = r_v;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_vwb_collect.sv
// Directed bench for vwb_collect: full commits, overflow, gapped input,
// abort, disturbance during WRITE and reset mid-WRITE.
module tb_vwb_collect;
    import vwb_pkg::*;

    localparam int LANES = 16;
    localparam int WIDTH = 16;
    localparam int NREG  = 8;

    typedef struct {
        int               elem;
        int               vreg;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    wr_t  wq[$];

    vwb_collect_if #(.LANES(LANES), .WIDTH(WIDTH), .NREG(NREG)) bus ();

    vwb_collect #(.LANES(LANES), .WIDTH(WIDTH), .NREG(NREG)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register-file write log and done-pulse counter.
    always @(negedge clk) begin
        if (rst_n && bus.rf_we === 1'b1)
            wq.push_back('{int'(bus.rf_elem), int'(bus.rf_vreg), bus.rf_wdata});
        if (bus.done === 1'b1)
            n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input int vreg, input bit with_abort);
        bus.cmd_start = 1'b1;
        bus.cmd_vreg  = 3'(vreg);
        bus.abort     = with_abort;
        step();
        bus.cmd_start = 1'b0;
        bus.abort     = 1'b0;
        wq.delete();
        check("start_ready", 32'(bus.in_ready), 32'd1);
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_v_clear", 32'(bus.V), 32'd0);
    endtask

    task automatic feed(input int first, input int count, input int ov_idx, input bit gaps);
        for (int i = first; i < first + count; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'hDEAD;
                bus.in_ov    = 1'b1;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i + 1);
            bus.in_ov    = (i == ov_idx);
            bus.in_sign  = (i == ov_idx);
            step();
            check("v_track", 32'(bus.V), 32'((ov_idx >= 0) && (i >= ov_idx)));
        end
        bus.in_valid = 1'b0;
        bus.in_ov    = 1'b0;
        bus.in_sign  = 1'b0;
    endtask

    task automatic finish_vec(input int vreg, input int ov_idx, input bit disturb);
        int               d0;
        logic [WIDTH-1:0] exp_data;
        check("first_we", 32'(bus.rf_we), 32'd1);
        check("first_elem", 32'(bus.rf_elem), 32'd0);
        d0 = n_done;
        for (int k = 0; k < LANES; k++) begin
            if (disturb && k >= 2 && k < 5) begin
                bus.cmd_start = 1'b1;
                bus.abort     = 1'b1;
                bus.cmd_vreg  = 3'(vreg + 1);
            end else begin
                bus.cmd_start = 1'b0;
                bus.abort     = 1'b0;
            end
            step();
        end
        check("done_pulse", 32'(bus.done), 32'd1);
        check("we_after_last", 32'(bus.rf_we), 32'd0);
        check("v_at_done", 32'(bus.V), 32'(ov_idx >= 0));
        step();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        check("done_count", 32'(n_done - d0), 32'd1);
        check("write_count", 32'(wq.size()), 32'(LANES));
        foreach (wq[j]) begin
            exp_data = 16'(j + 1);
`ifdef VWB_SAT_EN
            if (j == ov_idx) exp_data = 16'h8000;
`endif
            check("wr_elem", 32'(wq[j].elem), 32'(j));
            check("wr_vreg", 32'(wq[j].vreg), 32'(vreg));
            check("wr_data", 32'(wq[j].data), 32'(exp_data));
        end
        $display("vector vreg=%0d writes=%0d V=%0b", vreg, wq.size(), bus.V);
    endtask

    initial begin
        int d0;
        bus.cmd_start = 1'b0;
        bus.cmd_vreg  = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ov     = 1'b0;
        bus.in_sign   = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.rf_we), 32'd0);
        check("rst_vreg", 32'(bus.rf_vreg), 32'd0);
        check("rst_elem", 32'(bus.rf_elem), 32'd0);
        check("rst_wdata", 32'(bus.rf_wdata), 32'd0);
        check("rst_v", 32'(bus.V), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        step();

        // Clean vector into v3
        start_vec(3, 1'b0);
        feed(0, LANES, -1, 1'b0);
        finish_vec(3, -1, 1'b0);

        // Overflow on element 7; V stays set through IDLE
        start_vec(3, 1'b0);
        feed(0, LANES, 7, 1'b0);
        finish_vec(3, 7, 1'b0);
        repeat (3) step();
        check("v_held_idle", 32'(bus.V), 32'd1);

        // in_valid toggling every other cycle
        start_vec(4, 1'b0);
        feed(0, LANES, -1, 1'b1);
        finish_vec(4, -1, 1'b0);

        // Abort after 5 elements, element presented with abort is dropped
        start_vec(2, 1'b0);
        feed(0, 5, 2, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0006;
        bus.abort    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        check("abort_ready", 32'(bus.in_ready), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_v", 32'(bus.V), 32'd0);
        d0 = n_done;
        repeat (4) step();
        check("abort_no_we", 32'(wq.size()), 32'd0);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        $display("abort vreg=2 after 5 elements writes=%0d", wq.size());

        // cmd_start with abort in IDLE starts; then a normal commit
        start_vec(6, 1'b1);
        feed(0, LANES, -1, 1'b0);
        finish_vec(6, -1, 1'b0);

        // cmd_start and abort during WRITE are ignored
        start_vec(1, 1'b0);
        feed(0, LANES, -1, 1'b0);
        finish_vec(1, -1, 1'b1);

        // Reset in the middle of WRITE
        start_vec(5, 1'b0);
        feed(0, LANES, 3, 1'b0);
        check("mid_first_we", 32'(bus.rf_we), 32'd1);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("mrst_ready", 32'(bus.in_ready), 32'd0);
        check("mrst_we", 32'(bus.rf_we), 32'd0);
        check("mrst_vreg", 32'(bus.rf_vreg), 32'd0);
        check("mrst_elem", 32'(bus.rf_elem), 32'd0);
        check("mrst_wdata", 32'(bus.rf_wdata), 32'd0);
        check("mrst_v", 32'(bus.V), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_we", 32'(bus.rf_we), 32'd0);
        $display("reset mid-WRITE vreg=5 partial writes=%0d", wq.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
